// File: rtl/result_drain.sv
// result_drain: captures a 4x4 result matrix and streams it row-major over valid/ready; `RESULT_DRAIN_DOUBLEBUF_EN adds a shadow buffer
module result_drain (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [3:0][3:0][31:0] i_c,
  input  logic                  i_validResult,
  output logic                  o_ready,
  output logic [31:0]           o_data,
  output logic [1:0]            o_row,
  output logic [1:0]            o_col,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overflow,
  input  logic                  i_clearOverflow
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t r_state, w_state_n;
  logic [3:0] r_idx, w_idx_n;
  logic [3:0][3:0][31:0] r_act;
  logic r_ovf;
  logic w_accept, w_load_c;
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
  logic [3:0][3:0][31:0] r_sh;
  logic r_sfull, w_sfull_n, w_load_sh, w_swap;
`endif
  // outputs from registered state, then next state / buffer load decisions
  always_comb begin
    o_valid = r_state == DRAIN;
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
    o_ready = !r_sfull;
`else
    o_ready = r_state == IDLE;
`endif
    o_row = o_valid ? r_idx[3:2] : 2'd0;
    o_col = o_valid ? r_idx[1:0] : 2'd0;
    o_data = o_valid ? r_act[r_idx[3:2]][r_idx[1:0]] : 32'd0;
    o_last = o_valid && r_idx == 4'd15;
    o_overflow = r_ovf;
    w_accept = i_validResult && o_ready;
    w_state_n = r_state;
    w_idx_n = r_idx;
    w_load_c = 1'b0;
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
    w_swap = 1'b0;
    w_load_sh = 1'b0;
`endif
    if (r_state == IDLE) begin
      w_load_c = w_accept;
      w_idx_n = 4'd0;
      w_state_n = w_accept ? DRAIN : IDLE;
    end else if (i_ready) begin
      w_idx_n = r_idx + 4'd1;
      if (r_idx == 4'd15) begin
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
        w_swap = r_sfull;
        w_load_c = !r_sfull && w_accept;
        w_state_n = (r_sfull || w_accept) ? DRAIN : IDLE;
`else
        w_state_n = IDLE;
`endif
      end
    end
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
    w_load_sh = w_accept && r_state == DRAIN && !w_load_c;
    w_sfull_n = w_load_sh ? 1'b1 : w_swap ? 1'b0 : r_sfull;
`endif
  end
  // control state; a rejected strobe beats a same-cycle overflow clear
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_state <= IDLE;
      r_idx <= 4'd0;
      r_ovf <= 1'b0;
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
      r_sfull <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      r_ovf <= (i_validResult && !o_ready) || (r_ovf && !i_clearOverflow);
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
      r_sfull <= w_sfull_n;
`endif
    end
  end
  // data buffers need no reset: outputs are gated by o_valid
  always_ff @(posedge i_clk) begin
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
    if (w_load_c) r_act <= i_c;
    else if (w_swap) r_act <= r_sh;
    if (w_load_sh) r_sh <= i_c;
`else
    if (w_load_c) r_act <= i_c;
`endif
  end
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: queue-based reference model with per-cycle compare plus directed literal checks
module tb_result_drain;
`ifdef RESULT_DRAIN_DOUBLEBUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  logic clk = 1'b0;
  logic i_arst, i_validResult, i_ready, i_clearOverflow;
  logic [3:0][3:0][31:0] i_c;
  logic o_ready, o_last, o_valid, o_overflow;
  logic [31:0] o_data;
  logic [1:0] o_row, o_col;
  int total = 0;
  int bad = 0;
  logic [35:0] mq[$];
  bit movf = 1'b0;
  bit live = 1'b0;
  always #5 clk = ~clk;
  result_drain dut (
    .i_clk(clk), .i_arst(i_arst), .i_c(i_c), .i_validResult(i_validResult),
    .o_ready(o_ready), .o_data(o_data), .o_row(o_row), .o_col(o_col),
    .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_overflow(o_overflow), .i_clearOverflow(i_clearOverflow)
  );
  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endfunction
  function automatic bit model_ready();
    return DB ? (mq.size() <= 16) : (mq.size() == 0);
  endfunction
  // model: pending elements of all held results in output order
  always @(posedge clk) begin
    bit rdy;
    if (i_arst) begin
      mq.delete();
      movf = 1'b0;
      live = 1'b1;
    end else if (live) begin
      rdy = model_ready();
      if (mq.size() > 0 && i_ready) void'(mq.pop_front());
      if (i_validResult && rdy)
        for (int k = 0; k < 16; k++) mq.push_back({2'(k / 4), 2'(k % 4), i_c[k / 4][k % 4]});
      movf = (i_validResult && !rdy) ? 1'b1 : i_clearOverflow ? 1'b0 : movf;
    end
  end
  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    logic [35:0] e;
    bit ev;
    if (live) begin
      ev = mq.size() > 0;
      e = ev ? mq[0] : 36'd0;
      chk("cycle", {24'd0, o_valid, o_ready, o_overflow, o_last, o_row, o_col, o_data},
          {24'd0, ev, model_ready(), movf, ev && e[35:32] == 4'hF, e[35:34], e[33:32], e[31:0]});
    end
  end
  task automatic load(input logic [31:0] base, input int mul);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) i_c[r][c] = base + 32'(mul * r + c);
  endtask
  task automatic drain_out();
    int n = 0;
    i_validResult = 1'b0;
    i_ready = 1'b1;
    while (o_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain_timeout", 64'(o_valid), 64'd0);
  endtask
  initial begin
    int nv;
    int k;
    i_arst = 1'b1;
    i_validResult = 1'b0;
    i_ready = 1'b0;
    i_clearOverflow = 1'b0;
    i_c = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_ovf", 64'(o_overflow), 64'd0);
    chk("reset_outs", {27'd0, o_last, o_row, o_col, o_data}, 64'd0);
    i_arst = 1'b0;
    i_ready = 1'b1;
    load(32'd0, 16);
    i_validResult = 1'b1;
    @(negedge clk);
    i_validResult = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("basic_data", 64'(o_data), 64'(16 * (j / 4) + j % 4));
      chk("basic_last", 64'(o_last), 64'(j == 15));
      chk("basic_ready", 64'(o_ready), 64'(DB));
      @(negedge clk);
    end
    chk("basic_end", 64'(o_valid), 64'd0);
    load(32'hA000_0000, 4);
    i_validResult = 1'b1;
    @(negedge clk);
    i_validResult = 1'b0;
    nv = 0;
    k = 0;
    while (o_valid && nv < 60) begin
      i_ready = nv[0];
      if (i_ready) begin
        chk("bp_data", 64'(o_data), 64'(32'hA000_0000 + 32'(k)));
        k++;
      end
      nv++;
      @(negedge clk);
    end
    chk("bp_cycles", 64'(nv), 64'd32);
    chk("bp_count", 64'(k), 64'd16);
    i_ready = 1'b1;
    load(32'h100, 16);
    i_validResult = 1'b1;
    @(negedge clk);
    i_validResult = 1'b0;
    repeat (5) @(negedge clk);
    chk("idx5_data", 64'(o_data), 64'h111);
    load(32'h7700_0000, 4);
    i_validResult = 1'b1;
    @(negedge clk);
    i_validResult = 1'b0;
    chk("second_ovf", 64'(o_overflow), 64'(!DB));
    chk("second_ready", 64'(o_ready), 64'd0);
    nv = 6;
    while (o_valid && nv < 60) begin
      if (o_row == 2'd0 && o_col == 2'd0) chk("second_first", 64'(o_data), 64'h7700_0000);
      nv++;
      @(negedge clk);
    end
    chk("contig_cycles", 64'(nv), DB ? 64'd32 : 64'd16);
    i_clearOverflow = 1'b1;
    @(negedge clk);
    i_clearOverflow = 1'b0;
    chk("ovf_cleared", 64'(o_overflow), 64'd0);
    load(32'h300, 16);
    i_validResult = 1'b1;
    @(negedge clk);
    if (DB) begin
      load(32'h400, 16);
      @(negedge clk);
    end
    load(32'h500, 16);
    i_clearOverflow = 1'b1;
    @(negedge clk);
    i_validResult = 1'b0;
    i_clearOverflow = 1'b0;
    chk("set_wins", 64'(o_overflow), 64'd1);
    drain_out();
    i_clearOverflow = 1'b1;
    @(negedge clk);
    i_clearOverflow = 1'b0;
    load(32'h900, 16);
    i_validResult = 1'b1;
    @(negedge clk);
    i_validResult = 1'b0;
    repeat (7) @(negedge clk);
    chk("idx7_data", 64'(o_data), 64'h913);
    i_arst = 1'b1;
    i_validResult = 1'b1;
    @(negedge clk);
    i_arst = 1'b0;
    i_validResult = 1'b0;
    chk("rst_mid_valid", 64'(o_valid), 64'd0);
    chk("rst_mid_ready", 64'(o_ready), 64'd1);
    chk("rst_mid_outs", {27'd0, o_last, o_row, o_col, o_data}, 64'd0);
    load(32'h5500, 16);
    i_validResult = 1'b1;
    @(negedge clk);
    i_validResult = 1'b0;
    chk("restart_first", {30'd0, o_row, o_col, o_data}, 64'h5500);
    drain_out();
    for (int n = 0; n < 3000; n++) begin
      i_ready = $urandom_range(0, 3) != 0;
      i_validResult = $urandom_range(0, 9) == 0;
      i_clearOverflow = $urandom_range(0, 15) == 0;
      i_arst = $urandom_range(0, 299) == 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) i_c[r][c] = $urandom;
      @(negedge clk);
    end
    i_arst = 1'b0;
    i_clearOverflow = 1'b0;
    drain_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
